// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//   Owns the single write port of the picoMIPS GPR file (addresses BASE..BASE+NGPR-1)
//   and shares it between core writeback and a host/debug loader using round-robin
//   arbitration. It also walks a host dump of every GPR over the Raddr1 read port,
//   using only the cycles in which the core leaves that port idle.
//
// Ports
//   clk, reset                   clock and synchronous active-high reset
//   cw_valid/cw_addr/cw_data     core write request; cw_ready is the same-cycle grant
//   hw_valid/hw_addr/hw_data     host write request; hw_ready is the same-cycle grant
//   rf_w/rf_waddr/rf_wdata       registered write strobe, address and data to regs
//   core_rd_busy                 the core is using Raddr1 in this cycle
//   rf_rsel/rf_raddr/rf_rdata    Raddr1 override and the Rdata1 return path
//   dump_start                   pulse that starts a dump of all GPRs
//   dump_busy                    a dump is in progress
//   dv_valid/dv_ready            handshake for dump words
//   dv_data/dv_idx               dump word and its GPR index
//   dump_done                    one-cycle pulse after the last dump word is accepted
//   err_illegal                  sticky flag: a write to a non-writable address was accepted
module regfile_access_ctrl #(
    parameter int N    = 8,
    parameter int NGPR = 4,
    parameter int BASE = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cw_valid,
    input  logic [2:0]   cw_addr,
    input  logic [N-1:0] cw_data,
    output logic         cw_ready,
    input  logic         hw_valid,
    input  logic [2:0]   hw_addr,
    input  logic [N-1:0] hw_data,
    output logic         hw_ready,
    output logic         rf_w,
    output logic [2:0]   rf_waddr,
    output logic [N-1:0] rf_wdata,
    input  logic         core_rd_busy,
    output logic         rf_rsel,
    output logic [2:0]   rf_raddr,
    input  logic [N-1:0] rf_rdata,
    input  logic         dump_start,
    output logic         dump_busy,
    output logic         dv_valid,
    input  logic         dv_ready,
    output logic [N-1:0] dv_data,
    output logic [1:0]   dv_idx,
    output logic         dump_done,
    output logic         err_illegal
);

    localparam logic [2:0] BASE_A = 3'(BASE);
    localparam logic [1:0] LAST   = 2'(NGPR - 1);

    typedef enum logic {RR_CORE, RR_HOST} rr_t;
    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    function automatic logic addr_legal(input logic [2:0] a);
        return (int'(a) >= BASE) && (int'(a) < BASE + NGPR);
    endfunction

    rr_t            rr_last;
    logic           grant_c;
    logic           grant_h;
    logic           hs;
    logic [2:0]     sel_addr;
    logic [N-1:0]   sel_data;

    logic           w_p1;
    logic [2:0]     waddr_p1;
    logic [N-1:0]   wdata_p1;
    logic           err_q;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     idx;
    logic [1:0]     idx_nxt;
    logic [N-1:0]   dv_data_q;
    logic [1:0]     dv_idx_q;

    // Stage p0: combinational arbitration; ready is held low while in reset so
    // that no handshake can complete in a reset cycle.
    always_comb begin
        grant_c = 1'b0;
        grant_h = 1'b0;
        if (!reset) begin
            if (cw_valid && hw_valid) begin
                if (rr_last == RR_HOST) grant_c = 1'b1;
                else                    grant_h = 1'b1;
            end else begin
                grant_c = cw_valid;
                grant_h = hw_valid;
            end
        end
    end

    assign cw_ready = grant_c;
    assign hw_ready = grant_h;
    assign hs       = grant_c || grant_h;
    assign sel_addr = grant_h ? hw_addr : cw_addr;
    assign sel_data = grant_h ? hw_data : cw_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= RR_HOST;
        end else if (grant_c) begin
            rr_last <= RR_CORE;
        end else if (grant_h) begin
            rr_last <= RR_HOST;
        end
    end

    // Stage p1: registered write issue. An illegal address still completes its
    // handshake but only raises the sticky error instead of strobing regs.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_p1     <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            err_q    <= 1'b0;
        end else begin
            w_p1 <= hs && addr_legal(sel_addr);
            if (hs && addr_legal(sel_addr)) begin
                waddr_p1 <= sel_addr;
                wdata_p1 <= sel_data;
            end else begin
                waddr_p1 <= '0;
                wdata_p1 <= '0;
            end
            if (hs && !addr_legal(sel_addr)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rf_w        = w_p1;
    assign rf_waddr    = waddr_p1;
    assign rf_wdata    = wdata_p1;
    assign err_illegal = err_q;

    // Dump FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Dump FSM: next state
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nxt = READ;
                    idx_nxt   = '0;
                end
            end
            READ: begin
                // The core always owns Raddr1 when it asks for it.
                if (!core_rd_busy) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (dv_ready) begin
                    if (idx == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = READ;
                        idx_nxt   = idx + 2'd1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Dump FSM: outputs
    always_comb begin
        rf_rsel   = (state == READ) && !core_rd_busy;
        rf_raddr  = rf_rsel ? (BASE_A + {1'b0, idx}) : 3'd0;
        dv_valid  = (state == HOLD);
        dump_busy = (state != IDLE);
        dump_done = (state == DONE);
    end

    // Dump word capture: Rdata1 is sampled in the stolen read cycle, so a write
    // landing on the same edge is not visible in the captured word.
    always_ff @(posedge clk) begin
        if (reset) begin
            dv_data_q <= '0;
            dv_idx_q  <= '0;
        end else if (rf_rsel) begin
            dv_data_q <= rf_rdata;
            dv_idx_q  <= idx;
        end
    end

    assign dv_data = dv_data_q;
    assign dv_idx  = dv_idx_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cw_valid;
    logic [2:0] cw_addr;
    logic [7:0] cw_data;
    logic       cw_ready;
    logic       hw_valid;
    logic [2:0] hw_addr;
    logic [7:0] hw_data;
    logic       hw_ready;
    logic       rf_w;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       core_rd_busy;
    logic       rf_rsel;
    logic [2:0] rf_raddr;
    logic [7:0] rf_rdata;
    logic       dump_start;
    logic       dump_busy;
    logic       dv_valid;
    logic       dv_ready;
    logic [7:0] dv_data;
    logic [1:0] dv_idx;
    logic       dump_done;
    logic       err_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_access_ctrl #(.N(8), .NGPR(4), .BASE(3)) dut (
        .clk(clk), .reset(reset),
        .cw_valid(cw_valid), .cw_addr(cw_addr), .cw_data(cw_data), .cw_ready(cw_ready),
        .hw_valid(hw_valid), .hw_addr(hw_addr), .hw_data(hw_data), .hw_ready(hw_ready),
        .rf_w(rf_w), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .core_rd_busy(core_rd_busy), .rf_rsel(rf_rsel), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .dump_start(dump_start), .dump_busy(dump_busy),
        .dv_valid(dv_valid), .dv_ready(dv_ready), .dv_data(dv_data), .dv_idx(dv_idx),
        .dump_done(dump_done), .err_illegal(err_illegal)
    );

    // Register file model: writes land at the clock edge, reads are combinational.
    logic [7:0] gpr [4];

    always @(posedge clk) begin
        if (rf_w) begin
            case (rf_waddr)
                3'd3: gpr[0] <= rf_wdata;
                3'd4: gpr[1] <= rf_wdata;
                3'd5: gpr[2] <= rf_wdata;
                3'd6: gpr[3] <= rf_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rf_rdata = 8'h00;
        case (rf_raddr)
            3'd3: rf_rdata = gpr[0];
            3'd4: rf_rdata = gpr[1];
            3'd5: rf_rdata = gpr[2];
            3'd6: rf_rdata = gpr[3];
            default: rf_rdata = 8'h00;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       cv;
        logic [2:0] ca;
        logic [7:0] cd;
        logic       hv;
        logic [2:0] ha;
        logic [7:0] hd;
        logic       ecr;
        logic       ehr;
        logic       ew;
        logic [2:0] ewa;
        logic [7:0] ewd;
        logic       eerr;
    } vec_t;

    typedef struct {
        logic       w;
        logic [2:0] a;
        logic [7:0] d;
    } wexp_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] idx;
    } dexp_t;

    vec_t  vt [17];
    wexp_t wq [$];
    dexp_t dq [$];

    function automatic vec_t mk(input logic cv, input logic [2:0] ca, input logic [7:0] cd,
                                input logic hv, input logic [2:0] ha, input logic [7:0] hd,
                                input logic ecr, input logic ehr, input logic ew,
                                input logic [2:0] ewa, input logic [7:0] ewd, input logic eerr);
        vec_t v;
        v.cv = cv; v.ca = ca; v.cd = cd;
        v.hv = hv; v.ha = ha; v.hd = hd;
        v.ecr = ecr; v.ehr = ehr; v.ew = ew; v.ewa = ewa; v.ewd = ewd; v.eerr = eerr;
        return v;
    endfunction

    // Runs one dump from IDLE. Bit c of each mask applies to cycle c after the start:
    // bmask drives core_rd_busy, rlow forces dv_ready low, smask repeats dump_start.
    task automatic run_dump(input string nm, input logic [63:0] bmask,
                            input logic [63:0] rlow, input logic [63:0] smask);
        bit done_seen = 0;
        int last_acc  = -10;
        dq.delete();
        for (int k = 0; k < 4; k++) dq.push_back('{8'(17 * (k + 1)), 2'(k)});
        for (int c = 0; c < 64 && !done_seen; c++) begin
            dump_start   = (c == 0) || smask[c];
            core_rd_busy = bmask[c];
            dv_ready     = !rlow[c];
            #1;
            if (core_rd_busy) chk({nm, "_rsel_busy"}, 32'(rf_rsel), 32'd0);
            if (rf_rsel && dq.size() > 0) chk({nm, "_raddr"}, 32'(rf_raddr), 32'(3 + int'(dq[0].idx)));
            if (!rf_rsel) chk({nm, "_raddr_idle"}, 32'(rf_raddr), 32'd0);
            if (dv_valid) begin
                if (dq.size() == 0) begin
                    chk({nm, "_extra_word"}, 32'(dv_valid), 32'd0);
                end else begin
                    chk({nm, "_dv_data"}, 32'(dv_data), 32'(dq[0].d));
                    chk({nm, "_dv_idx"}, 32'(dv_idx), 32'(dq[0].idx));
                    if (dv_ready) begin
                        void'(dq.pop_front());
                        last_acc = c;
                    end
                end
            end
            if (dump_done) begin
                done_seen = 1;
                chk({nm, "_done_latency"}, 32'(c - last_acc), 32'd1);
                chk({nm, "_words_left"}, 32'(dq.size()), 32'd0);
            end
            @(posedge clk); #1;
        end
        dump_start   = 1'b0;
        core_rd_busy = 1'b0;
        dv_ready     = 1'b0;
        chk({nm, "_done_seen"}, 32'(done_seen), 32'd1);
        chk({nm, "_done_one_cycle"}, 32'(dump_done), 32'd0);
        chk({nm, "_idle_after"}, 32'(dump_busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wexp_t e;
        bit found;

        vt[0]  = mk(1'b1, 3'd4, 8'hA1, 1'b1, 3'd5, 8'hB1, 1'b1, 1'b0, 1'b1, 3'd4, 8'hA1, 1'b0);
        vt[1]  = mk(1'b1, 3'd4, 8'hA2, 1'b1, 3'd5, 8'hB1, 1'b0, 1'b1, 1'b1, 3'd5, 8'hB1, 1'b0);
        vt[2]  = mk(1'b1, 3'd4, 8'hA2, 1'b1, 3'd5, 8'hB2, 1'b1, 1'b0, 1'b1, 3'd4, 8'hA2, 1'b0);
        vt[3]  = mk(1'b1, 3'd4, 8'hA3, 1'b1, 3'd5, 8'hB2, 1'b0, 1'b1, 1'b1, 3'd5, 8'hB2, 1'b0);
        vt[4]  = mk(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        vt[5]  = mk(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h5A, 1'b0);
        vt[6]  = mk(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h77, 1'b0, 1'b1, 1'b1, 3'd6, 8'h77, 1'b0);
        vt[7]  = mk(1'b1, 3'd6, 8'h80, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 8'h80, 1'b0);
        vt[8]  = mk(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
        vt[9]  = mk(1'b1, 3'd7, 8'h12, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        vt[10] = mk(1'b1, 3'd2, 8'hEE, 1'b1, 3'd3, 8'h33, 1'b0, 1'b1, 1'b1, 3'd3, 8'h33, 1'b1);
        vt[11] = mk(1'b1, 3'd3, 8'h44, 1'b1, 3'd4, 8'h55, 1'b1, 1'b0, 1'b1, 3'd3, 8'h44, 1'b1);
        vt[12] = mk(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h55, 1'b0, 1'b1, 1'b1, 3'd4, 8'h55, 1'b1);
        vt[13] = mk(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h11, 1'b0, 1'b1, 1'b1, 3'd3, 8'h11, 1'b1);
        vt[14] = mk(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h22, 1'b0, 1'b1, 1'b1, 3'd4, 8'h22, 1'b1);
        vt[15] = mk(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h33, 1'b0, 1'b1, 1'b1, 3'd5, 8'h33, 1'b1);
        vt[16] = mk(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h44, 1'b0, 1'b1, 1'b1, 3'd6, 8'h44, 1'b1);

        reset = 1'b1;
        cw_valid = 1'b0; cw_addr = 3'd0; cw_data = 8'h00;
        hw_valid = 1'b0; hw_addr = 3'd0; hw_data = 8'h00;
        core_rd_busy = 1'b0; dump_start = 1'b0; dv_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_cw_ready", 32'(cw_ready), 32'd0);
        chk("rst_hw_ready", 32'(hw_ready), 32'd0);
        chk("rst_rf_w", 32'(rf_w), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_rf_rsel", 32'(rf_rsel), 32'd0);
        chk("rst_rf_raddr", 32'(rf_raddr), 32'd0);
        chk("rst_dump_busy", 32'(dump_busy), 32'd0);
        chk("rst_dv_valid", 32'(dv_valid), 32'd0);
        chk("rst_dv_data", 32'(dv_data), 32'd0);
        chk("rst_dv_idx", 32'(dv_idx), 32'd0);
        chk("rst_dump_done", 32'(dump_done), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);

        // Write arbitration and issue vectors
        for (int i = 0; i < 17; i++) begin
            cw_valid = vt[i].cv; cw_addr = vt[i].ca; cw_data = vt[i].cd;
            hw_valid = vt[i].hv; hw_addr = vt[i].ha; hw_data = vt[i].hd;
            #1;
            chk($sformatf("v%0d_cw_ready", i), 32'(cw_ready), 32'(vt[i].ecr));
            chk($sformatf("v%0d_hw_ready", i), 32'(hw_ready), 32'(vt[i].ehr));
            wq.push_back('{vt[i].ew, vt[i].ewa, vt[i].ewd});
            @(posedge clk); #1;
            e = wq.pop_front();
            chk($sformatf("v%0d_rf_w", i), 32'(rf_w), 32'(e.w));
            if (e.w) begin
                chk($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'(e.a));
                chk($sformatf("v%0d_rf_wdata", i), 32'(rf_wdata), 32'(e.d));
            end
            chk($sformatf("v%0d_err", i), 32'(err_illegal), 32'(vt[i].eerr));
        end
        cw_valid = 1'b0;
        hw_valid = 1'b0;

        // Plain dump of the preloaded GPRs
        run_dump("dump1", 64'h0, 64'h0, 64'h0);

        // Core holds Raddr1 for 3 cycles, consumer stalls 2 cycles, stray restart ignored
        run_dump("dump2", 64'h0E, 64'h60, 64'h20);
        chk("err_sticky", 32'(err_illegal), 32'd1);

        // Reset while holding word idx 2
        found = 0;
        dump_start = 1'b1;
        for (int c = 0; c < 40 && !found; c++) begin
            dv_ready = 1'b0;
            #1;
            if (dv_valid && dv_idx == 2'd2) begin
                found = 1;
            end else begin
                dv_ready = dv_valid;
                @(posedge clk); #1;
                dump_start = 1'b0;
            end
        end
        chk("mid_reached_idx2", 32'(found), 32'd1);
        reset = 1'b1;
        dump_start = 1'b0;
        dv_ready = 1'b0;
        cw_valid = 1'b1; cw_addr = 3'd4; cw_data = 8'h99;
        @(posedge clk); #1;
        reset = 1'b0;
        cw_valid = 1'b0;
        #1;
        chk("mid_dump_busy", 32'(dump_busy), 32'd0);
        chk("mid_dv_valid", 32'(dv_valid), 32'd0);
        chk("mid_dump_done", 32'(dump_done), 32'd0);
        chk("mid_rf_w", 32'(rf_w), 32'd0);
        chk("mid_err_cleared", 32'(err_illegal), 32'd0);
        @(posedge clk); #1;
        chk("mid_no_done_later", 32'(dump_done), 32'd0);
        chk("mid_still_idle", 32'(dump_busy), 32'd0);

        // Fresh dump restarts at idx 0 and shows the dropped write never landed
        run_dump("dump3", 64'h0, 64'h0, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
